// File: rtl/seg_scan_driver.sv
// rtl/seg_scan_driver.sv - multiplexed seven-segment scan driver with frame-boundary double buffering
// Optional: define LEADING_ZERO_BLANK_EN to auto-blank leading zero digits.
module seg_scan_driver #(
  parameter int NUM_DIGITS  = 8,
  parameter int REFRESH_DIV = 100000,
  parameter int GAP_CYCLES  = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  output logic [3:0]              number,
  output logic                    dec_point,
  output logic [NUM_DIGITS-1:0]   anode,
  output logic                    frame_tick,
  output logic                    load_ack
);

  localparam int CNT_MAX = (REFRESH_DIV > GAP_CYCLES) ? REFRESH_DIV : GAP_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int IDX_W   = (NUM_DIGITS > 2) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  typedef enum logic {S_GAP, S_ON} state_t;

  state_t                  state;
  logic [CNT_W-1:0]        cnt;
  logic [IDX_W-1:0]        idx;
  logic                    first;
  logic                    pending;
  logic [4*NUM_DIGITS-1:0] act_value, shd_value;
  logic [NUM_DIGITS-1:0]   act_dp, shd_dp;
  logic [NUM_DIGITS-1:0]   act_blank, shd_blank;

  logic [IDX_W-1:0]        tgt;
  logic                    gap_done;
  logic                    commit;
  logic [4*NUM_DIGITS-1:0] nxt_value;
  logic [NUM_DIGITS-1:0]   nxt_dp;
  logic [NUM_DIGITS-1:0]   nxt_blank;
  logic [NUM_DIGITS-1:0]   eff_blank;
  logic [NUM_DIGITS-1:0]   anode_sel;

  // nxt_* is the content the upcoming digit is drawn from: on a commit it is the
  // newly committed frame, so digit 0 already shows it in the first ON cycle.
  always_comb begin
    tgt       = (first || idx == IDX_LAST) ? '0 : idx + 1'b1;
    gap_done  = (state == S_GAP) && (cnt == GAP_LAST);
    commit    = gap_done && (tgt == '0) && (pending || load);
    nxt_value = act_value;
    nxt_dp    = act_dp;
    nxt_blank = act_blank;
    if (commit) begin
      nxt_value = load ? value_in : shd_value;
      nxt_dp    = load ? dp_in    : shd_dp;
      nxt_blank = load ? blank_in : shd_blank;
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic zero_run;
`endif

  always_comb begin
    eff_blank = nxt_blank;
`ifdef LEADING_ZERO_BLANK_EN
    zero_run = 1'b1;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      zero_run     = zero_run && (nxt_value[4*i +: 4] == 4'h0) && !nxt_dp[i];
      eff_blank[i] = eff_blank[i] | zero_run;
    end
`endif
    anode_sel = '1;
    if (!eff_blank[tgt]) anode_sel[tgt] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_GAP;
      cnt        <= '0;
      idx        <= '0;
      first      <= 1'b1;
      pending    <= 1'b0;
      act_value  <= '0;
      act_dp     <= '0;
      act_blank  <= '1;
      shd_value  <= '0;
      shd_dp     <= '0;
      shd_blank  <= '0;
      number     <= 4'h0;
      dec_point  <= 1'b0;
      anode      <= '1;
      frame_tick <= 1'b0;
      load_ack   <= 1'b0;
    end else begin
      frame_tick <= 1'b0;
      load_ack   <= 1'b0;
      if (load) begin
        shd_value <= value_in;
        shd_dp    <= dp_in;
        shd_blank <= blank_in;
        pending   <= 1'b1;
      end
      if (commit) begin
        act_value <= nxt_value;
        act_dp    <= nxt_dp;
        act_blank <= nxt_blank;
        pending   <= 1'b0;
        load_ack  <= 1'b1;
      end
      case (state)
        S_GAP: begin
          if (gap_done) begin
            state      <= S_ON;
            cnt        <= '0;
            idx        <= tgt;
            first      <= 1'b0;
            anode      <= anode_sel;
            number     <= nxt_value[4*tgt +: 4];
            dec_point  <= nxt_dp[tgt];
            frame_tick <= (tgt == '0);
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_ON: begin
          if (cnt == ON_LAST) begin
            state <= S_GAP;
            cnt   <= '0;
            anode <= '1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// tb/tb_seg_scan_driver.sv - scoreboard bench for seg_scan_driver (honours LEADING_ZERO_BLANK_EN)
module tb_seg_scan_driver;

  localparam int N = 4;
  localparam int R = 8;
  localparam int G = 2;
  localparam int P = N * (R + G);

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load = 1'b0;
  logic [15:0] value_in = '0;
  logic [3:0]  dp_in = '0;
  logic [3:0]  blank_in = '0;
  logic [3:0]  number;
  logic        dec_point;
  logic [3:0]  anode;
  logic        frame_tick;
  logic        load_ack;

  typedef struct {
    bit          ack;
    logic [15:0] value;
    logic [3:0]  dp;
    logic [3:0]  blank;
  } frame_t;

  typedef struct {
    int          edge_n;
    logic [15:0] value;
    logic [3:0]  dp;
    logic [3:0]  blank;
  } plan_t;

  frame_t exp_q[$];
  plan_t  plan_q[$];
  int     n_tests = 0;
  int     n_fail = 0;

  seg_scan_driver #(.NUM_DIGITS(N), .REFRESH_DIV(R), .GAP_CYCLES(G)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .value_in(value_in), .dp_in(dp_in),
    .blank_in(blank_in), .number(number), .dec_point(dec_point), .anode(anode),
    .frame_tick(frame_tick), .load_ack(load_ack)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_tests++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
    end
  endtask

  function automatic bit eff_blank(input frame_t f, input int d);
    bit b;
    b = f.blank[d];
`ifdef LEADING_ZERO_BLANK_EN
    if (d > 0 && (f.value >> (4 * d)) == 16'h0 && (f.dp >> d) == 4'h0) b = 1'b1;
`endif
    return b;
  endfunction

  task automatic add_plan(input int e, input logic [15:0] v, input logic [3:0] d, input logic [3:0] b);
    plan_t p;
    p.edge_n = e; p.value = v; p.dp = d; p.blank = b;
    plan_q.push_back(p);
  endtask

  // Stimulus plus frame-level model: each frame boundary pushes what the frame must show.
  task automatic drive(input int n_frames, input bit rand_en);
    frame_t      act, shd;
    bit          pend, ld, is_b;
    logic [15:0] v;
    logic [3:0]  d, b;
    int          nz;
    pend = 1'b0;
    act.ack = 1'b0; act.value = '0; act.dp = '0; act.blank = 4'hF;
    shd.ack = 1'b0; shd.value = '0; shd.dp = '0; shd.blank = 4'h0;
    for (int e = 1; e <= G + (n_frames - 1) * P; e++) begin
      is_b = (e >= G) && ((e - G) % P == 0);
      nz = $urandom_range(0, 4);
      v = 16'($urandom);
      v = v >> (4 * nz);
      d = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
      b = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      ld = 1'b0;
      if (plan_q.size() > 0 && plan_q[0].edge_n == e) begin
        ld = 1'b1;
        v = plan_q[0].value; d = plan_q[0].dp; b = plan_q[0].blank;
        void'(plan_q.pop_front());
      end else if (rand_en && ($urandom_range(0, 19) == 0 || (is_b && $urandom_range(0, 2) == 0))) begin
        ld = 1'b1;
      end
      load = ld; value_in = v; dp_in = d; blank_in = b;
      if (is_b) begin
        if (ld) begin
          act.value = v; act.dp = d; act.blank = b;
        end else if (pend) begin
          act.value = shd.value; act.dp = shd.dp; act.blank = shd.blank;
        end
        act.ack = ld || pend;
        pend = 1'b0;
        exp_q.push_back(act);
      end else if (ld) begin
        shd.value = v; shd.dp = d; shd.blank = b;
        pend = 1'b1;
      end
      @(negedge clk);
    end
    load = 1'b0;
  endtask

  task automatic monitor(input int n_frames);
    frame_t     f;
    int         w, dg, ph;
    logic [3:0] exp_an;
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (!frame_tick && w < G + P);
    check("first_tick_delay", w, G);
    for (int k = 0; k < n_frames; k++) begin
      check("queue_nonempty", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) f = exp_q.pop_front();
      else begin
        f.ack = 1'b0; f.value = '0; f.dp = '0; f.blank = 4'hF;
      end
      for (int c = 0; c < P; c++) begin
        if (k > 0 || c > 0) @(negedge clk);
        dg = c / (R + G);
        ph = c % (R + G);
        check("frame_tick", frame_tick, c == 0);
        check("load_ack", load_ack, (c == 0) && f.ack);
        if (ph < R) begin
          exp_an = eff_blank(f, dg) ? 4'hF : (4'hF ^ (4'b0001 << dg));
          check("anode_on", anode, exp_an);
          check("number", number, (f.value >> (4 * dg)) & 16'hF);
          check("dec_point", dec_point, f.dp[dg]);
        end else begin
          check("anode_gap", anode, 4'hF);
        end
      end
    end
  endtask

  task automatic run_phase(input int n_frames, input bit rand_en);
    rst_n = 1'b0;
    load = 1'b0;
    exp_q.delete();
    repeat (3) @(negedge clk);
    check("rst_anode", anode, 4'hF);
    check("rst_number", number, 4'h0);
    check("rst_dec_point", dec_point, 1'b0);
    check("rst_frame_tick", frame_tick, 1'b0);
    check("rst_load_ack", load_ack, 1'b0);
    rst_n = 1'b1;
    fork
      drive(n_frames, rand_en);
      monitor(n_frames);
    join
  endtask

  // Commit 1234, then pull reset asynchronously while digit 2 is lit.
  task automatic reset_mid_on();
    rst_n = 1'b0;
    load = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int e = 1; e <= G + P + 2 * (R + G) + 3; e++) begin
      load = (e == 5);
      value_in = 16'h1234; dp_in = 4'h0; blank_in = 4'h0;
      @(negedge clk);
    end
    load = 1'b0;
    check("pre_reset_anode", anode, 4'b1011);
    check("pre_reset_number", number, 4'h2);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_anode", anode, 4'hF);
    check("async_reset_number", number, 4'h0);
  endtask

  initial begin
    run_phase(3, 1'b0);
    add_plan(G + P + 10,     16'h12A4, 4'b0010, 4'b0000);
    add_plan(G + 2 * P + 5,  16'h1111, 4'b0000, 4'b0000);
    add_plan(G + 2 * P + 20, 16'h2222, 4'b0000, 4'b0000);
    add_plan(G + 4 * P,      16'h00F0, 4'b0000, 4'b0000);
    add_plan(G + 5 * P + 7,  16'h0070, 4'b0000, 4'b0000);
    run_phase(8, 1'b0);
    reset_mid_on();
    run_phase(2, 1'b0);
    run_phase(12, 1'b1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
